// File: rtl/aftab_signed_multiplier.sv
// Sequential signed/unsigned shift-add multiplier for the AFTAB AAU; start/done pulse handshake.
// Optional early termination when the multiplier runs out of set bits: define AFTAB_MUL_EARLY_TERM_EN.
module aftab_signed_multiplier #(
  parameter int size = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                startSMul,
  input  logic                SignedUnsignedbar,
  input  logic [size-1:0]     multiplicand,
  input  logic [size-1:0]     multiplier,
  output logic                busySMul,
  output logic                doneSMul,
  output logic [2*size-1:0]   productOut
);

  localparam int CW = $clog2(size + 1);
  localparam logic [CW-1:0] LAST = CW'(size);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              pState, nState;
  logic [2*size-1:0]   acc, mcand;
  logic [size-1:0]     mr;
  logic [CW-1:0]       count;
  logic                negRes;

  logic [size-1:0]     magA, magB;
  logic                finish;
  logic [2*size-1:0]   finalProd;

  always_comb begin
    magA = (SignedUnsignedbar && multiplicand[size-1]) ? -multiplicand : multiplicand;
    magB = (SignedUnsignedbar && multiplier[size-1])   ? -multiplier   : multiplier;
`ifdef AFTAB_MUL_EARLY_TERM_EN
    // Once mr has no set bits left the remaining iterations cannot change acc.
    finish = (count == LAST) || (mr == '0);
`else
    finish = (count == LAST);
`endif
    // Zero accumulator is never negated, so negative zero cannot appear.
    finalProd = (negRes && (acc != '0)) ? -acc : acc;
  end

  always_comb begin
    nState = pState;
    unique case (pState)
      IDLE:    if (startSMul) nState = CALC;
      CALC:    if (finish)    nState = DONE;
      DONE:                   nState = IDLE;
      default:                nState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pState     <= IDLE;
      acc        <= '0;
      mcand      <= '0;
      mr         <= '0;
      count      <= '0;
      negRes     <= 1'b0;
      productOut <= '0;
    end else begin
      pState <= nState;
      unique case (pState)
        IDLE: begin
          if (startSMul) begin
            acc    <= '0;
            mcand  <= {{size{1'b0}}, magA};
            mr     <= magB;
            count  <= '0;
            negRes <= SignedUnsignedbar & (multiplicand[size-1] ^ multiplier[size-1]);
          end
        end
        CALC: begin
          if (finish) begin
            productOut <= finalProd;
          end else begin
            if (mr[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mr    <= mr >> 1;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busySMul = (pState != IDLE);
  assign doneSMul = (pState == DONE);

endmodule

// File: doc/aftab_signed_multiplier.md
Name: aftab_signed_multiplier

Overview:
- Sequential shift-add multiplier for the AFTAB AAU; the multiply counterpart of the signed divider.
- Converts operands to magnitudes when signed mode is selected, runs an unsigned shift-add core, then two's-complements the double-width product if the operand signs differ.
- Sits beside the divider in the AAU; the AAU controller drives it with the same start/done pulse handshake.

Parameters:
- size, 33, operand width (32-bit data plus sign-extension bit); product is 2*size bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- startSMul  input  1  one-cycle start pulse; sampled only in IDLE
- SignedUnsignedbar  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start
- multiplicand  input  size  operand A; sampled with start
- multiplier  input  size  operand B; sampled with start
- busySMul  output  1  high from the edge that accepts start until doneSMul falls
- doneSMul  output  1  one-cycle pulse; productOut is valid in this cycle
- productOut  output  2*size  registered product; held until the next accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; busySMul = 0; doneSMul = 0; productOut = 0.
  - All internal registers and the counter are cleared.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE to CALC on a rising edge with startSMul = 1 (edge E0). At E0:
  - magA = |multiplicand| and magB = |multiplier| when SignedUnsignedbar = 1 and the MSB = 1; otherwise the raw value.
  - negRes = SignedUnsignedbar & (A[size-1] ^ B[size-1]).
  - acc (2*size) = 0; mcand (2*size) = zero-extended magA; mr (size) = magB; count = 0.
- Magnitude of -2^(size-1) is 2^(size-1) and fits unsigned in size bits. No overflow is possible in 2*size bits.
- CALC, one iteration per edge:
  - if mr[0] = 1, acc += mcand;
  - mcand <<= 1; mr >>= 1; count++.
  - After size iterations (edge E_size), go to DONE.
- DONE, at edge E_size+1:
  - productOut = negRes ? (~acc + 1) : acc, truncated to 2*size bits.
  - doneSMul = 1 for exactly this one cycle; next state = IDLE.
  - busySMul falls together with doneSMul.
- Latency (macro off): doneSMul is high in the cycle after edge E0 + (size+1) edges, i.e. 34 edges after the start edge at size = 33.
- A zero operand needs no special case: the result is 0, with negRes forced off for a zero accumulator (never output negative zero).
- startSMul while busy: ignored, no restart, operands not re-sampled.
- startSMul in the same cycle doneSMul is high: the FSM is in DONE, not IDLE, so start is ignored. The controller must issue start from IDLE.
- Operand input changes after E0 have no effect.
- productOut is unchanged from DONE until the next DONE; it is not cleared by start.

Optional Feature:
- Macro: AFTAB_MUL_EARLY_TERM_EN.
- Defined:
  - In CALC, when mr == 0 at the start of an iteration, go to DONE without iterating.
  - The product is unchanged because the remaining iterations would add nothing.
  - Iteration count k = bit length of magB (0 when magB = 0); done is high in the cycle after edge E0 + (k+1).
  - Example: multiplier = 5 means done after 4 edges; multiplier = 0 means done after 1 edge.
  - busySMul and doneSMul rules are otherwise identical.
- Undefined: always exactly size iterations; latency fixed at size+1 edges.

Test Plan:
- Signed -3 x 5 (SignedUnsignedbar=1, A=0x1_FFFF_FFFD, B=0x0_0000_0005) -> productOut = 66-bit -15 (all ones except low bits 0x...F1); done at edge 34; busy high over edges 1..34.
- Unsigned 0x1_FFFF_FFFF x 0x0_0000_0002 (SignedUnsignedbar=0) -> productOut = 0x3_FFFF_FFFE; negRes = 0.
- Signed most-negative squared, A=B=0x1_0000_0000 -> productOut = 2^64 = 0x1_0000_0000_0000_0000, positive.
- Zero case: signed -7 x 0 -> productOut = 0 (not negative zero). With AFTAB_MUL_EARLY_TERM_EN, done comes 1 edge after start.
- Start pulse again at edge 10 with new operands -> ignored; result and timing match the first operation; busy stays high.
- Assert rst=0 at edge 15 mid-CALC -> busySMul, doneSMul and productOut go to 0 immediately (async); a fresh start after release completes normally.
